exec_trace_buffer: RTL and testbench
====================================

Name: exec_trace_buffer

Overview:
- Debug capture stage directly downstream of the single-cycle CPU core.
- Consumes the core's per-cycle PC, Inst and ALU result R outputs.
- Records them in a circular buffer with a PC-match trigger and a configurable post-trigger window.
- After capture completes, a read handshake drains the samples oldest-first for the display/readout logic.

Parameters:
DEPTH, 16, buffer entries; power of 2, minimum 4
AW, 4, log2(DEPTH)
POST, 8, samples captured after the trigger sample; 0 to DEPTH-1

Ports:
Clk  in  1  system clock, same clock as CPU
Clrn  in  1  asynchronous active-low reset
Step  in  1  CPU retired an instruction this cycle; tie high for a free-running single-cycle core
PC  in  32  CPU program counter
Inst  in  32  CPU current instruction
R  in  32  CPU ALU result
Arm  in  1  one-cycle pulse: clear buffer and start capture
TrigEn  in  1  enable PC-match trigger
TrigPC  in  32  trigger address
RdReq  in  1  request next stored sample
RdData  out  96  {PC, Inst, R} of popped sample
RdValid  out  1  RdData valid, one-cycle pulse
Count  out  AW+1  samples currently held, 0..DEPTH
State  out  2  0 IDLE, 1 ARMED, 2 POST, 3 DONE
Done  out  1  high while State==DONE

Behaviour:
- Reset (Clrn low, asynchronous, effective immediately): State=IDLE, wptr=0, rptr=0, Count=0, postcnt=0, RdValid=0, RdData=0, Done=0. Memory contents are not cleared (don't care).
- Arm has priority over every other input in every state. On Arm: wptr=0, rptr=0, Count=0, postcnt=POST, RdValid=0; next State=ARMED. A Step in the same cycle is discarded.
- IDLE: Step, RdReq and the trigger are ignored.
- ARMED, on Step:
  - write {PC,Inst,R} at wptr; wptr=(wptr+1) mod DEPTH.
  - Count increments, saturating at DEPTH; at DEPTH the oldest entry is overwritten.
  - If TrigEn and PC==TrigPC, the trigger sample is written, then: POST==0 -> DONE, else -> POST.
  - TrigEn=0: capture runs indefinitely until Arm.
- POST, on Step:
  - write as in ARMED; postcnt decrements.
  - The write with postcnt==1 moves State to DONE.
  - PC matches are ignored.
- Entry to DONE (registered in the transition cycle): rptr=(wptr_after_last_write - Count) mod DEPTH, i.e. the oldest held sample. No further writes; Step is ignored.
- DONE read handshake:
  - RdReq with Count>0: next cycle RdValid=1, RdData=mem[rptr]; rptr=(rptr+1) mod DEPTH; Count decrements.
  - Back-to-back RdReq gives one sample per cycle.
  - RdReq with Count==0 is ignored (RdValid stays 0).
  - State remains DONE when Count reaches 0.
- RdReq outside DONE is ignored. RdValid is 0 on every cycle without an accepted request. RdData holds its last value otherwise.
- Total samples in a complete capture = (samples up to and including trigger) + POST, capped at DEPTH held.
- PC compare is exact 32-bit equality; pointer arithmetic wraps modulo DEPTH.
- Done = (State==DONE), combinational from the state register.

Test Plan:
1. Assert Clrn low with arbitrary inputs -> State=0, Count=0, RdValid=0, RdData=0, Done=0.
2. Arm, TrigEn=1, TrigPC=0x0C, Step each cycle with PC=0,4,8,...; POST=8 -> DONE after 12th Step (PC 0x2C), Count=12; 12 RdReq pulses return PC 0x00..0x2C in order, each RdValid 1 cycle after its RdReq; Count ends 0.
3. Wrap-around with TrigPC=0x50, DEPTH=16, POST=8 -> 29 samples stepped, Count=16; first read PC=0x34, last PC=0x70 with matching Inst/R.
4. Arm and Step in the same cycle -> sample dropped, Count=0. Arm while DONE with Count=5 -> State=1, Count=0, Done=0.
5. RdReq while ARMED -> no RdValid, Count unchanged. RdReq in DONE with Count=0 -> no RdValid.
6. Clrn pulsed low mid-POST -> State=0, Count=0, Done=0 immediately. Later Steps with PC==TrigPC are ignored until Arm.

Source files
------------

// File: rtl/exec_trace_buffer.sv
// Execution trace buffer for the single-cycle core.
// Captures {PC, Inst, R} into a circular buffer.
// A PC match starts a post-trigger window of POST more samples.
// Once capture is done, the held samples are read back oldest-first.
module exec_trace_buffer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int POST  = 8
) (
    input  logic          Clk,
    input  logic          Clrn,
    input  logic          Step,
    input  logic [31:0]   PC,
    input  logic [31:0]   Inst,
    input  logic [31:0]   R,
    input  logic          Arm,
    input  logic          TrigEn,
    input  logic [31:0]   TrigPC,
    input  logic          RdReq,
    output logic [95:0]   RdData,
    output logic          RdValid,
    output logic [AW:0]   Count,
    output logic [1:0]    State,
    output logic          Done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_POST  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [AW:0]   L_FULL   = (AW+1)'(DEPTH);
    localparam logic [AW:0]   L_ONE_C  = (AW+1)'(1);
    localparam logic [AW-1:0] L_ONE_P  = AW'(1);
    localparam logic [AW-1:0] L_POST   = AW'(POST);

    state_t        r_state;
    state_t        w_nextState;
    logic [95:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW-1:0] r_postcnt;
    logic [AW:0]   r_count;
    logic          r_rdValid;
    logic [95:0]   r_rdData;

    logic          w_capturing;
    logic          w_write;
    logic          w_read;
    logic          w_trigHit;
    logic          w_enterDone;
    logic [AW-1:0] w_wptrInc;
    logic [AW:0]   w_countSat;

    // Decode write/read qualifiers and the next FSM state; Arm overrides everything.
    always_comb begin
        w_nextState = r_state;
        w_capturing = (r_state == S_ARMED) || (r_state == S_POST);
        w_write     = !Arm && Step && w_capturing;
        w_read      = !Arm && RdReq && (r_state == S_DONE) && (r_count != '0);
        w_trigHit   = TrigEn && (PC == TrigPC);
        w_wptrInc   = r_wptr + L_ONE_P;
        w_countSat  = (r_count == L_FULL) ? r_count : (r_count + L_ONE_C);
        if (Arm) begin
            w_nextState = S_ARMED;
        end else begin
            case (r_state)
                S_ARMED: begin
                    if (Step && w_trigHit) begin
                        w_nextState = (POST == 0) ? S_DONE : S_POST;
                    end
                end
                S_POST: begin
                    if (Step && (r_postcnt == L_ONE_P)) begin
                        w_nextState = S_DONE;
                    end
                end
                default: begin
                    w_nextState = r_state;
                end
            endcase
        end
        w_enterDone = w_write && (w_nextState == S_DONE);
    end

    // FSM state register.
    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Sample storage; contents are never cleared, only the pointers are.
    always_ff @(posedge Clk) begin
        if (w_write) begin
            r_mem[r_wptr] <= {PC, Inst, R};
        end
    end

    // Pointers, occupancy, post-trigger countdown and the read port.
    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_postcnt <= '0;
            r_rdValid <= 1'b0;
            r_rdData  <= '0;
        end else begin
            r_rdValid <= 1'b0;
            if (Arm) begin
                r_wptr    <= '0;
                r_rptr    <= '0;
                r_count   <= '0;
                r_postcnt <= L_POST;
            end else if (w_write) begin
                r_wptr  <= w_wptrInc;
                r_count <= w_countSat;
                if (r_state == S_POST) begin
                    r_postcnt <= r_postcnt - L_ONE_P;
                end
                if (w_enterDone) begin
                    r_rptr <= w_wptrInc - w_countSat[AW-1:0];
                end
            end else if (w_read) begin
                r_rdValid <= 1'b1;
                r_rdData  <= r_mem[r_rptr];
                r_rptr    <= r_rptr + L_ONE_P;
                r_count   <= r_count - L_ONE_C;
            end
        end
    end

    assign RdData  = r_rdData;
    assign RdValid = r_rdValid;
    assign Count   = r_count;
    assign State   = r_state;
    assign Done    = (r_state == S_DONE);

endmodule

// File: tb/tb_exec_trace_buffer.sv
// Directed scoreboard bench for exec_trace_buffer.
// Captured samples are queued as they are stepped in.
// Each returned read is compared against the head of that queue.
module tb_exec_trace_buffer;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int POSTN = 8;

    logic          Clk = 1'b0;
    logic          Clrn;
    logic          Step;
    logic [31:0]   PC;
    logic [31:0]   Inst;
    logic [31:0]   R;
    logic          Arm;
    logic          TrigEn;
    logic [31:0]   TrigPC;
    logic          RdReq;
    logic [95:0]   RdData;
    logic          RdValid;
    logic [AW:0]   Count;
    logic [1:0]    State;
    logic          Done;

    int            testsRun = 0;
    int            testsFailed = 0;
    logic [95:0]   sbQ[$];
    int            mState;
    int            mPost;
    logic [95:0]   lastData;

    exec_trace_buffer #(.DEPTH(DEPTH), .AW(AW), .POST(POSTN)) dut (
        .Clk(Clk), .Clrn(Clrn), .Step(Step), .PC(PC), .Inst(Inst), .R(R),
        .Arm(Arm), .TrigEn(TrigEn), .TrigPC(TrigPC), .RdReq(RdReq),
        .RdData(RdData), .RdValid(RdValid), .Count(Count), .State(State), .Done(Done)
    );

    // Free-running clock.
    always #5 Clk = ~Clk;

    function automatic logic [95:0] mkSample(input logic [31:0] pc);
        logic [31:0] inst;
        logic [31:0] res;
        inst = pc ^ 32'hC0DE_0000;
        res  = pc * 32'd3 + 32'd7;
        return {pc, inst, res};
    endfunction

    task automatic checkOutput(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            testsFailed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkStatus(input string tag);
        checkOutput({tag, " state"}, 96'(State), 96'(mState));
        checkOutput({tag, " count"}, 96'(Count), 96'(sbQ.size()));
        checkOutput({tag, " done"}, 96'(Done), 96'(mState == 3));
    endtask

    task automatic applyStimulus(input logic [31:0] pc);
        logic [95:0] s;
        s    = mkSample(pc);
        Step = 1'b1;
        PC   = s[95:64];
        Inst = s[63:32];
        R    = s[31:0];
        @(posedge Clk);
        #1;
        Step = 1'b0;
        if (mState == 1 || mState == 2) begin
            sbQ.push_back(s);
            if (sbQ.size() > DEPTH) void'(sbQ.pop_front());
            if (mState == 1) begin
                if (TrigEn && pc == TrigPC) begin
                    mPost  = POSTN;
                    mState = (POSTN == 0) ? 3 : 2;
                end
            end else begin
                mPost--;
                if (mPost == 0) mState = 3;
            end
        end
    endtask

    task automatic doArm(input logic withStep);
        Arm  = 1'b1;
        Step = withStep;
        PC   = 32'h0;
        @(posedge Clk);
        #1;
        Arm  = 1'b0;
        Step = 1'b0;
        sbQ.delete();
        mState = 1;
        mPost  = POSTN;
    endtask

    task automatic doRead(input string tag);
        logic [95:0] exp;
        RdReq = 1'b1;
        @(posedge Clk);
        #1;
        RdReq = 1'b0;
        if (mState == 3 && sbQ.size() > 0) begin
            exp = sbQ.pop_front();
            checkOutput({tag, " valid"}, 96'(RdValid), 96'(1));
            checkOutput({tag, " data"}, RdData, exp);
            lastData = exp;
        end else begin
            checkOutput({tag, " novalid"}, 96'(RdValid), 96'(0));
            checkOutput({tag, " hold"}, RdData, lastData);
        end
    endtask

    initial begin
        // Reset with arbitrary inputs applied.
        Clrn = 1'b0; Step = 1'b1; Arm = 1'b0; TrigEn = 1'b1; TrigPC = 32'h0;
        RdReq = 1'b1; PC = 32'h1234_5678; Inst = 32'hDEAD_BEEF; R = 32'h5555_AAAA;
        mState = 0; mPost = 0; lastData = '0;
        #12;
        checkStatus("reset");
        checkOutput("reset rdvalid", 96'(RdValid), 96'(0));
        checkOutput("reset rddata", RdData, 96'h0);
        @(negedge Clk);
        Clrn = 1'b1; Step = 1'b0; RdReq = 1'b0;
        applyStimulus(32'h0);
        checkStatus("idle step");
        doRead("idle read");

        // Basic trigger capture and ordered drain.
        TrigEn = 1'b1; TrigPC = 32'h0C;
        doArm(1'b0);
        checkStatus("arm");
        for (int i = 0; i < 12; i++) applyStimulus(32'(i * 4));
        checkStatus("capture12");
        checkOutput("capture12 count", 96'(Count), 96'(12));
        checkOutput("capture12 state", 96'(State), 96'(3));
        applyStimulus(32'h30);
        checkStatus("done step ignored");
        for (int i = 0; i < 12; i++) doRead("drain12");
        checkOutput("drain12 last pc", 96'(RdData[95:64]), 96'(32'h2C));
        checkStatus("drained");
        doRead("empty read");
        checkOutput("rdvalid idle", 96'(RdValid), 96'(0));

        // Wrap-around: trigger late so the oldest samples are overwritten.
        TrigPC = 32'h50;
        doArm(1'b0);
        for (int i = 0; i < 29; i++) applyStimulus(32'(i * 4));
        checkStatus("wrap");
        checkOutput("wrap count", 96'(Count), 96'(16));
        doRead("wrap first");
        checkOutput("wrap first pc", 96'(RdData[95:64]), 96'(32'h34));
        for (int i = 0; i < 15; i++) doRead("wrap");
        checkOutput("wrap last pc", 96'(RdData[95:64]), 96'(32'h70));
        checkStatus("wrap drained");

        // Arm with Step in the same cycle drops the sample.
        doArm(1'b1);
        checkStatus("arm+step");
        TrigPC = 32'h0C;
        for (int i = 0; i < 12; i++) applyStimulus(32'(i * 4));
        for (int i = 0; i < 7; i++) doRead("partial");
        checkOutput("partial count", 96'(Count), 96'(5));
        doArm(1'b0);
        checkStatus("rearm from done");

        // Reads while armed are ignored.
        TrigEn = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus(32'(i * 4));
        doRead("armed read");
        checkStatus("armed read");

        // Asynchronous reset in the middle of the post-trigger window.
        TrigEn = 1'b1;
        doArm(1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(32'(i * 4));
        checkStatus("mid post");
        #2;
        Clrn = 1'b0;
        #1;
        sbQ.delete(); mState = 0; lastData = '0;
        checkStatus("async reset");
        checkOutput("async reset rdvalid", 96'(RdValid), 96'(0));
        #1;
        Clrn = 1'b1;
        applyStimulus(32'h0C);
        checkStatus("idle trigger ignored");

        // Trigger disabled: capture saturates and keeps running.
        TrigEn = 1'b0;
        doArm(1'b0);
        for (int i = 0; i < 20; i++) applyStimulus(32'h0C);
        checkStatus("free run");
        checkOutput("free run count", 96'(Count), 96'(16));

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
